fma_issue_ctrl: RTL and testbench
=================================

# fma_issue_ctrl

Issue controller and arbiter for the three-stage FMA unit (preMul → mul-add/postMul → round) in the dual-issue FPU. Two issue pipes (i0, i1) share one FMA instance; the block grants issue slots round-robin, drives the FMA stage-register enables, and tracks valid/tag/source per stage. It also holds results in the round stage under writeback backpressure. All FMA operands and results pass outside this block; it carries only control.

## Interface
Parameters:
- TAG_W, 5, width of destination tag carried alongside each operation

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  pipe i0 requests an FMA op
- req0_ready  out  1  i0 request accepted this cycle
- req0_op  in  7  one-hot {fadd, fsub, fmul, fmadd, fmsub, fnmsub, fnmadd}
- req0_fp64  in  1  double-precision op
- req0_rm  in  3  rounding mode
- req0_tag  in  TAG_W  destination tag
- req1_valid, req1_ready, req1_op, req1_fp64, req1_rm, req1_tag: same as i0, for pipe i1
- flush  in  1  kill all in-flight ops
- fma_sel  out  1  operand-mux select for FMA inputs (0 = i0, 1 = i1)
- fma_ctrl_code  out  7  ctrl code of granted request; 0 when none
- fma_fp64  out  1  fp64 of granted request
- fma_rm  out  3  rm of granted request
- e2_data_en  out  1  FMA e1→e2 register enable
- e3_data_en  out  1  FMA e2→e3 register enable
- wb_valid  out  1  FMA output (round stage) holds a live result
- wb_tag  out  TAG_W  tag of that result
- wb_src  out  1  originating pipe of that result
- wb_ready  in  1  writeback consumes result this cycle
- busy  out  1  v2 | v3

## Operation
- State: v2, v3 (stage valids); tag2/src2 and tag3/src3; rr pointer (1 bit, the preferred requester).
- Grant (combinational): if exactly one reqN_valid, grant N. If both are valid, grant rr. fma_sel, fma_ctrl_code, fma_fp64 and fma_rm mux from the granted request. With no request, fma_ctrl_code = 0 and fma_sel = rr.
- adv3 = v2 & (!v3 | wb_ready) & !flush
- adv2 = grant_any & (!v2 | adv3) & !flush
- e3_data_en = adv3; e2_data_en = adv2.
- reqN_ready = adv2 & granted==N. An accept is a valid/ready handshake. A requester holds valid and payload stable until ready.
- Next state:
  - v2 ← adv2 | (v2 & !adv3)
  - v3 ← adv3 | (v3 & !wb_ready)
  - tag2/src2 load on adv2; tag3/src3 load on adv3.
- rr ← !granted-index on every accept; otherwise rr is unchanged.
- wb_valid = v3 & !flush; wb_tag = tag3; wb_src = src3.
- Flush: v2 ← 0 and v3 ← 0 next cycle. In the flush cycle, ready, e2_data_en, e3_data_en and wb_valid are all 0. rr is unchanged.
- reqN_op is one-hot by contract; the block does not check it.
- Reset: v2 = v3 = 0, rr = 0, tags and srcs = 0. While rst is high, all readies and enables are forced to 0. After reset, wb_valid = 0 and busy = 0.

## Timing
- Accept in cycle T (e2_data_en = 1). e3_data_en = 1 in T+1 if the round stage is free or draining. wb_valid = 1 in T+2; the FMA round output is combinational in that cycle. Latency is 2 cycles and throughput is 1 op/cycle.
- Stall on wb_ready = 0 with v3 = 1:
  - e3 holds; e3_data_en = 0.
  - e2 holds if v2 = 1; new accepts are blocked when v2 = 1.
  - At most 2 ops are held in flight, plus the accept in e1 that cycle.
- Simultaneous wb_ready = 1, adv3 and adv2 in one cycle: all three stages shift. No bubble.
- Flush together with wb_ready = 1: the result is not written back (wb_valid is already masked).
- Flush together with both requests valid: neither is accepted. Both are re-arbitrated next cycle using the unchanged rr.

## Test plan
- Single op: i0 fmadd, fp64 = 1, rm = 3, tag = 7 at T.
  - Required: req0_ready = 1 and e2_data_en = 1 at T; e3_data_en = 1 at T+1; wb_valid = 1, wb_tag = 7, wb_src = 0 at T+2; fma_ctrl_code = 7'b0001000, fma_fp64 = 1, fma_rm = 3 at T.
- Contention: i0 and i1 both valid for 4 cycles from reset, tags 1 and 2.
  - Required: grants i0, i1, i0, i1 (rr starts at 0); wb_tag sequence 1, 2, 1, 2 from T+2, one result per cycle.
- Backpressure: stream 4 ops, then hold wb_ready = 0 for 3 cycles.
  - Required: v3 and v2 hold; the third request sees ready = 0; no e2/e3 enables during the hold; no tag lost or duplicated once wb_ready = 1.
  - Then raise wb_ready = 1 with a request valid in the same cycle. Required: all stages advance in that cycle.
- Flush: flush while v2 = v3 = 1 and req1 is valid.
  - Required: wb_valid = 0 and req1_ready = 0 in the flush cycle; busy = 0 the next cycle; req1 accepted the following cycle.
- Reset mid-stream: assert rst with both stages full.
  - Required: next cycle v2 = v3 = 0, wb_valid = 0, rr = 0. While rst is high, all enables and readies are 0.

Source files
------------

// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl: round-robin issue arbiter for the shared three-stage FMA.
// Tracks valid/tag/source for the mul-add (e2) and round (e3) stages, drives
// the FMA stage-register enables and holds the round-stage result under
// writeback backpressure. Carries control only; operands pass outside.
module fma_issue_ctrl #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [6:0]       req0_op,
    input  logic             req0_fp64,
    input  logic [2:0]       req0_rm,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [6:0]       req1_op,
    input  logic             req1_fp64,
    input  logic [2:0]       req1_rm,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic             fma_sel,
    output logic [6:0]       fma_ctrl_code,
    output logic             fma_fp64,
    output logic [2:0]       fma_rm,
    output logic             e2_data_en,
    output logic             e3_data_en,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_src,
    input  logic             wb_ready,
    output logic             busy
);

    localparam int unsigned OP_W = 7;

    logic             v2_q, v2_d;
    logic             v3_q, v3_d;
    logic             rr_q, rr_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;
    logic             src2_q, src2_d;
    logic             src3_q, src3_d;

    logic             grant_any;
    logic             gnt_idx;
    logic             adv2;
    logic             adv3;

    // Arbitration, operand-mux steering and stage-advance decisions.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        gnt_idx   = (req0_valid & req1_valid) ? rr_q : req1_valid;

        fma_sel       = grant_any ? gnt_idx : rr_q;
        fma_ctrl_code = OP_W'(0);
        if (grant_any) begin
            fma_ctrl_code = gnt_idx ? req1_op : req0_op;
        end
        fma_fp64 = fma_sel ? req1_fp64 : req0_fp64;
        fma_rm   = fma_sel ? req1_rm : req0_rm;

        // Reset and flush both suppress every handshake and enable.
        adv3 = v2_q & (~v3_q | wb_ready) & ~flush & ~rst;
        adv2 = grant_any & (~v2_q | adv3) & ~flush & ~rst;

        e3_data_en = adv3;
        e2_data_en = adv2;
        req0_ready = adv2 & ~gnt_idx;
        req1_ready = adv2 & gnt_idx;

        wb_valid = v3_q & ~flush;
        wb_tag   = tag3_q;
        wb_src   = src3_q;
        busy     = v2_q | v3_q;
    end

    // Next-state for stage valids, per-stage tag/source and round-robin pointer.
    always_comb begin
        v2_d   = v2_q;
        v3_d   = v3_q;
        rr_d   = rr_q;
        tag2_d = tag2_q;
        src2_d = src2_q;
        tag3_d = tag3_q;
        src3_d = src3_q;

        if (flush) begin
            v2_d = 1'b0;
            v3_d = 1'b0;
        end else begin
            v2_d = adv2 | (v2_q & ~adv3);
            v3_d = adv3 | (v3_q & ~wb_ready);
        end

        if (adv2) begin
            tag2_d = gnt_idx ? req1_tag : req0_tag;
            src2_d = gnt_idx;
            rr_d   = ~gnt_idx;
        end

        if (adv3) begin
            tag3_d = tag2_q;
            src3_d = src2_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            rr_q   <= 1'b0;
            tag2_q <= TAG_W'(0);
            src2_q <= 1'b0;
            tag3_q <= TAG_W'(0);
            src3_q <= 1'b0;
        end else begin
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            rr_q   <= rr_d;
            tag2_q <= tag2_d;
            src2_q <= src2_d;
            tag3_q <= tag3_d;
            src3_q <= src3_d;
        end
    end

endmodule

// File: tb/tb_fma_issue_ctrl.sv
// Testbench for fma_issue_ctrl: directed scenarios plus a randomized run
// against an in-order queue model of the ops in flight.
module tb_fma_issue_ctrl;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_fp64;
    logic [6:0]       req0_op;
    logic [2:0]       req0_rm;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready, req1_fp64;
    logic [6:0]       req1_op;
    logic [2:0]       req1_rm;
    logic [TAG_W-1:0] req1_tag;
    logic             flush;
    logic             fma_sel, fma_fp64;
    logic [6:0]       fma_ctrl_code;
    logic [2:0]       fma_rm;
    logic             e2_data_en, e3_data_en;
    logic             wb_valid, wb_src, wb_ready, busy;
    logic [TAG_W-1:0] wb_tag;

    int checks = 0;
    int errors = 0;

    fma_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_fp64(req0_fp64), .req0_rm(req0_rm), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_fp64(req1_fp64), .req1_rm(req1_rm), .req1_tag(req1_tag),
        .flush(flush), .fma_sel(fma_sel), .fma_ctrl_code(fma_ctrl_code),
        .fma_fp64(fma_fp64), .fma_rm(fma_rm),
        .e2_data_en(e2_data_en), .e3_data_en(e3_data_en),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_src(wb_src),
        .wb_ready(wb_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: ops in flight, oldest first; in_rnd marks the op that
    // has reached the round stage (only the oldest can be there).
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             src;
        logic             in_rnd;
    } op_t;

    op_t  q[$];
    logic m_rr;

    logic       e_any, e_gidx, e_sel, e_adv2, e_adv3, e_wbv, e_busy;
    logic       e_r0rdy, e_r1rdy;
    logic [6:0] e_code;

    function automatic void model_eval();
        logic has_rnd, has_mid;
        has_rnd = (q.size() > 0) && q[0].in_rnd;
        has_mid = (q.size() > 0) && !q[q.size()-1].in_rnd;
        e_any   = req0_valid || req1_valid;
        e_gidx  = (req0_valid && req1_valid) ? m_rr : req1_valid;
        e_sel   = e_any ? e_gidx : m_rr;
        e_code  = !e_any ? 7'd0 : (e_gidx ? req1_op : req0_op);
        e_wbv   = has_rnd && !flush;
        e_adv3  = has_mid && (!has_rnd || wb_ready) && !flush && !rst;
        e_adv2  = e_any && (!has_mid || e_adv3) && !flush && !rst;
        e_r0rdy = e_adv2 && !e_gidx;
        e_r1rdy = e_adv2 && e_gidx;
        e_busy  = q.size() > 0;
    endfunction

    function automatic void model_update();
        op_t t;
        if (rst) begin
            q.delete();
            m_rr = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && q[0].in_rnd && wb_ready) void'(q.pop_front());
            if (e_adv3) begin
                t = q[0];
                t.in_rnd = 1'b1;
                q[0] = t;
            end
            if (e_adv2) begin
                t.tag    = e_gidx ? req1_tag : req0_tag;
                t.src    = e_gidx;
                t.in_rnd = 1'b0;
                q.push_back(t);
                m_rr = !e_gidx;
            end
        end
    endfunction

    task automatic advance();
        model_eval();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_op = 7'd0; req0_fp64 = 1'b0; req0_rm = 3'd0; req0_tag = '0;
        req1_valid = 1'b0; req1_op = 7'd0; req1_fp64 = 1'b0; req1_rm = 3'd0; req1_tag = '0;
        flush = 1'b0;
        wb_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = 7'b1000000;
        req1_valid = 1'b1; req1_op = 7'b0100000;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_r0rdy got %b want 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_r1rdy got %b want 0", req1_ready); end
        checks++; if (e2_data_en !== 1'b0) begin errors++; $display("FAIL rst_e2 got %b want 0", e2_data_en); end
        advance();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wbv got %b want 0", wb_valid); end
        checks++; if (fma_sel !== 1'b0) begin errors++; $display("FAIL rst_rr got %b want 0", fma_sel); end
        checks++; if (fma_ctrl_code !== 7'd0) begin errors++; $display("FAIL rst_code got %b want 0", fma_ctrl_code); end
        advance();
    endtask

    task automatic test_single_op();
        do_reset();
        req0_valid = 1'b1; req0_op = 7'b0001000; req0_fp64 = 1'b1; req0_rm = 3'd3; req0_tag = TAG_W'(7);
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_rdy got %b want 1", req0_ready); end
        checks++; if (e2_data_en !== 1'b1) begin errors++; $display("FAIL single_e2 got %b want 1", e2_data_en); end
        checks++; if (fma_ctrl_code !== 7'b0001000) begin errors++; $display("FAIL single_code got %b want 0001000", fma_ctrl_code); end
        checks++; if (fma_fp64 !== 1'b1) begin errors++; $display("FAIL single_fp64 got %b want 1", fma_fp64); end
        checks++; if (fma_rm !== 3'd3) begin errors++; $display("FAIL single_rm got %0d want 3", fma_rm); end
        advance();
        idle();
        @(negedge clk);
        checks++; if (e3_data_en !== 1'b1) begin errors++; $display("FAIL single_e3 got %b want 1", e3_data_en); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_wbv_early got %b want 0", wb_valid); end
        advance();
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL single_wbv got %b want 1", wb_valid); end
        checks++; if (wb_tag !== TAG_W'(7)) begin errors++; $display("FAIL single_tag got %0d want 7", wb_tag); end
        checks++; if (wb_src !== 1'b0) begin errors++; $display("FAIL single_src got %b want 0", wb_src); end
        advance();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", busy); end
        advance();
    endtask

    task automatic test_contention();
        logic             want_g;
        logic [TAG_W-1:0] want_t;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req0_valid = (i < 4); req0_op = 7'b0010000; req0_tag = TAG_W'(1);
            req1_valid = (i < 4); req1_op = 7'b0000100; req1_tag = TAG_W'(2);
            @(negedge clk);
            want_g = 1'(i % 2);
            if (i < 4) begin
                checks++; if (req0_ready !== !want_g) begin errors++; $display("FAIL cont_r0rdy c%0d got %b want %b", i, req0_ready, !want_g); end
                checks++; if (req1_ready !== want_g) begin errors++; $display("FAIL cont_r1rdy c%0d got %b want %b", i, req1_ready, want_g); end
                checks++; if (fma_ctrl_code !== (want_g ? 7'b0000100 : 7'b0010000)) begin errors++; $display("FAIL cont_code c%0d got %b", i, fma_ctrl_code); end
            end
            if (i >= 2) begin
                want_t = ((i % 2) == 0) ? TAG_W'(1) : TAG_W'(2);
                checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL cont_wbv c%0d got %b want 1", i, wb_valid); end
                checks++; if (wb_tag !== want_t) begin errors++; $display("FAIL cont_tag c%0d got %0d want %0d", i, wb_tag, want_t); end
            end
            advance();
        end
        idle();
        repeat (2) advance();
    endtask

    task automatic test_backpressure();
        logic [TAG_W-1:0] seen[$];
        logic             want_acc, want_e3, want_wbv;
        logic [TAG_W-1:0] want_t;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle();
            wb_ready = !(i >= 4 && i <= 6);
            if (i <= 7) begin
                req0_valid = 1'b1; req0_op = 7'b0000010;
                req0_tag = (i < 4) ? TAG_W'(10 + i) : TAG_W'(14);
            end
            @(negedge clk);
            want_acc = (i < 4) || (i == 7);
            want_e3  = (i >= 1 && i <= 3) || (i == 7) || (i == 8);
            want_wbv = (i >= 2);
            want_t   = (i < 4) ? TAG_W'(8 + i) : (i <= 7) ? TAG_W'(12) : TAG_W'(5 + i);
            checks++; if (req0_ready !== want_acc) begin errors++; $display("FAIL bp_rdy c%0d got %b want %b", i, req0_ready, want_acc); end
            checks++; if (e2_data_en !== want_acc) begin errors++; $display("FAIL bp_e2 c%0d got %b want %b", i, e2_data_en, want_acc); end
            checks++; if (e3_data_en !== want_e3) begin errors++; $display("FAIL bp_e3 c%0d got %b want %b", i, e3_data_en, want_e3); end
            checks++; if (wb_valid !== want_wbv) begin errors++; $display("FAIL bp_wbv c%0d got %b want %b", i, wb_valid, want_wbv); end
            if (want_wbv) begin
                checks++; if (wb_tag !== want_t) begin errors++; $display("FAIL bp_tag c%0d got %0d want %0d", i, wb_tag, want_t); end
            end
            if (i >= 4 && i <= 6) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy c%0d got %b want 1", i, busy); end
            end
            if (wb_valid && wb_ready) seen.push_back(wb_tag);
            advance();
        end
        checks++;
        if (seen.size() != 5) begin
            errors++; $display("FAIL bp_count got %0d want 5", seen.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (seen[k] !== TAG_W'(10 + k)) begin errors++; $display("FAIL bp_order idx %0d got %0d want %0d", k, seen[k], 10 + k); end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        req0_valid = 1'b1; req0_op = 7'b0000001; req0_tag = TAG_W'(3);
        advance();
        req0_tag = TAG_W'(4);
        advance();
        idle();
        req1_valid = 1'b1; req1_op = 7'b0100000; req1_tag = TAG_W'(9);
        flush = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_full got %b want 1", busy); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fl_wbv got %b want 0", wb_valid); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL fl_r1rdy got %b want 0", req1_ready); end
        checks++; if (e2_data_en !== 1'b0 || e3_data_en !== 1'b0) begin errors++; $display("FAIL fl_en got %b%b want 00", e2_data_en, e3_data_en); end
        advance();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy got %b want 0", busy); end
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL fl_accept got %b want 1", req1_ready); end
        advance();
        idle();
        req0_valid = 1'b1; req0_op = 7'b0000001;
        advance();
        req1_valid = 1'b1; req1_op = 7'b0100000;
        flush = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL fl_both got %b%b want 00", req0_ready, req1_ready); end
        advance();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL fl_rr got %b want 1", req1_ready); end
        advance();
        idle();
        repeat (3) advance();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        req0_valid = 1'b1; req0_op = 7'b0001000; req0_tag = TAG_W'(5);
        advance();
        req0_tag = TAG_W'(6);
        advance();
        req1_valid = 1'b1; req1_op = 7'b0000010;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL mrst_rdy got %b%b want 00", req0_ready, req1_ready); end
        checks++; if (e2_data_en !== 1'b0 || e3_data_en !== 1'b0) begin errors++; $display("FAIL mrst_en got %b%b want 00", e2_data_en, e3_data_en); end
        advance();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", busy); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mrst_wbv got %b want 0", wb_valid); end
        checks++; if (fma_sel !== 1'b0) begin errors++; $display("FAIL mrst_rr got %b want 0", fma_sel); end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (!req0_valid || e_r0rdy) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op    = 7'(7'd1 << $urandom_range(0, 6));
                req0_fp64  = 1'($urandom);
                req0_rm    = 3'($urandom);
                req0_tag   = TAG_W'($urandom);
            end
            if (!req1_valid || e_r1rdy) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op    = 7'(7'd1 << $urandom_range(0, 6));
                req1_fp64  = 1'($urandom);
                req1_rm    = 3'($urandom);
                req1_tag   = TAG_W'($urandom);
            end
            flush    = ($urandom_range(0, 15) == 0);
            wb_ready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            model_eval();
            checks++; if (req0_ready !== e_r0rdy) begin errors++; $display("FAIL rnd_r0rdy c%0d got %b want %b", i, req0_ready, e_r0rdy); end
            checks++; if (req1_ready !== e_r1rdy) begin errors++; $display("FAIL rnd_r1rdy c%0d got %b want %b", i, req1_ready, e_r1rdy); end
            checks++; if (e2_data_en !== e_adv2) begin errors++; $display("FAIL rnd_e2 c%0d got %b want %b", i, e2_data_en, e_adv2); end
            checks++; if (e3_data_en !== e_adv3) begin errors++; $display("FAIL rnd_e3 c%0d got %b want %b", i, e3_data_en, e_adv3); end
            checks++; if (wb_valid !== e_wbv) begin errors++; $display("FAIL rnd_wbv c%0d got %b want %b", i, wb_valid, e_wbv); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy c%0d got %b want %b", i, busy, e_busy); end
            checks++; if (fma_sel !== e_sel) begin errors++; $display("FAIL rnd_sel c%0d got %b want %b", i, fma_sel, e_sel); end
            checks++; if (fma_ctrl_code !== e_code) begin errors++; $display("FAIL rnd_code c%0d got %b want %b", i, fma_ctrl_code, e_code); end
            if (e_any) begin
                checks++;
                if (fma_fp64 !== (e_gidx ? req1_fp64 : req0_fp64) || fma_rm !== (e_gidx ? req1_rm : req0_rm)) begin
                    errors++; $display("FAIL rnd_fmt c%0d got %b/%0d", i, fma_fp64, fma_rm);
                end
            end
            if (e_wbv) begin
                checks++;
                if (wb_tag !== q[0].tag || wb_src !== q[0].src) begin
                    errors++; $display("FAIL rnd_wb c%0d got %0d/%b want %0d/%b", i, wb_tag, wb_src, q[0].tag, q[0].src);
                end
            end
            advance();
        end
        rst = 1'b0;
        idle();
        advance();
    endtask

    initial begin
        m_rr = 1'b0;
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
